turn_ctrl: RTL

Parametrised turn controller for keypad-driven multi-player games. Sits between `keypad_scan` and the game datapath. Extends the two-player `turn` block with:
- N players;
- a per-turn countdown timer with automatic hand-off on timeout;
- a consecutive-timeout game-over rule;
- an external `finish` input.

It drives the turn-enable and active-player outputs that feed the game counters, random generator and status LEDs.

---
 rtl/turn_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/turn_ctrl.sv
// rtl/turn_ctrl.sv - N-player turn controller with per-turn timer and timeout game-over
module turn_ctrl #(
  parameter int         NUM_PLAYERS  = 2,
  parameter int         TURN_TICKS   = 50_000_000,
  parameter int         MAX_TIMEOUTS = 3,
  parameter logic [3:0] KEY_START    = 4'd10,
  parameter logic [3:0] KEY_END      = 4'd11,
  localparam int        PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int        TW = $clog2(TURN_TICKS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             key_code,
  input  logic                   key_valid,
  input  logic                   finish,
  output logic                   en,
  output logic [PW-1:0]          whose,
  output logic [NUM_PLAYERS-1:0] player_led,
  output logic                   turn_start,
  output logic                   timeout,
  output logic [TW-1:0]          time_left,
  output logic                   game_over
);

  localparam int CW = $clog2(MAX_TIMEOUTS + 1);
  localparam logic [TW-1:0] TICKS = TW'(TURN_TICKS);
  localparam logic [CW-1:0] MAXT  = CW'(MAX_TIMEOUTS);
  localparam logic [PW-1:0] LASTP = PW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HANDOFF, DONE} state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            tcnt, tcnt_n, tcnt_inc;
  logic [PW-1:0]            whose_n;
  logic [TW-1:0]            time_left_n;
  logic                     turn_start_n, timeout_n, en_n, game_over_n;
  logic [NUM_PLAYERS-1:0]   led_n;
  logic                     start_key, end_key;

  assign start_key = key_valid && (key_code == KEY_START);
  assign end_key   = key_valid && (key_code == KEY_END);
  assign tcnt_inc  = tcnt + CW'(1);

  always_comb begin
    state_n      = state;
    whose_n      = whose;
    time_left_n  = time_left;
    tcnt_n       = tcnt;
    turn_start_n = 1'b0;
    timeout_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start_key) begin
          state_n      = ACTIVE;
          whose_n      = '0;
          time_left_n  = TICKS;
          tcnt_n       = '0;
          turn_start_n = 1'b1;
        end
      end
      ACTIVE: begin
        // finish beats KEY_END, which beats expiry; only a bare expiry pulses timeout
        if (finish) begin
          state_n = DONE;
        end else if (end_key) begin
          state_n = HANDOFF;
          tcnt_n  = '0;
        end else if (time_left == TW'(1)) begin
          timeout_n = 1'b1;
          tcnt_n    = tcnt_inc;
          state_n   = (tcnt_inc == MAXT) ? DONE : HANDOFF;
        end else begin
          time_left_n = time_left - TW'(1);
        end
      end
      HANDOFF: begin
        state_n      = ACTIVE;
        whose_n      = (whose == LASTP) ? '0 : whose + PW'(1);
        time_left_n  = TICKS;
        turn_start_n = 1'b1;
      end
      DONE: begin
        if (start_key) begin
          state_n     = IDLE;
          whose_n     = '0;
          time_left_n = '0;
          tcnt_n      = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    en_n        = (state_n == ACTIVE);
    game_over_n = (state_n == DONE);
    led_n       = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      led_n[i] = en_n && (whose_n == PW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      whose      <= '0;
      time_left  <= '0;
      en         <= 1'b0;
      player_led <= '0;
      turn_start <= 1'b0;
      timeout    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      whose      <= whose_n;
      time_left  <= time_left_n;
      en         <= en_n;
      player_led <= led_n;
      turn_start <= turn_start_n;
      timeout    <= timeout_n;
      game_over  <= game_over_n;
    end
  end

endmodule
